// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl single-port RAM controller:
// FSM state encoding, access-counter width and the legal RAM latency range.
package mem_ctrl_pkg;

  // Controller states; the encoding is fixed here so every user agrees on it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Access counters (optional feature) width and saturation value.
  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Supported RAM read latency range, in cycles.
  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 3;
  localparam int LAT_CNT_W = $clog2(LAT_MAX + 1);

endpackage

// File: rtl/mem_ctrl_sat_counter.sv
// Saturating event counter used for the optional read/write access counters
// (only instantiated when MEM_CTRL_ACCESS_COUNT_EN is defined).
module mem_ctrl_sat_counter
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Add one unless already at the top; the count sticks at CNT_MAX.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Count one per inc pulse, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: bridges a blocking core load/store port onto a synchronous
// single-port RAM with a configurable read latency (1..3 cycles).
// A request is registered on acceptance; the RAM sees a one-cycle enable and
// the core gets a one-cycle core_ready pulse on completion.
// Optional feature: define MEM_CTRL_ACCESS_COUNT_EN to add saturating
// rd_count / wr_count outputs counting completed reads and writes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter  int MEM_WIDTH   = 32,
  parameter  int MEM_SIZE    = 256,
  parameter  int RAM_LATENCY = 1,
  localparam int AW          = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        core_addr,
  input  logic                 core_read_en,
  input  logic                 core_write_en,
  input  logic [MEM_WIDTH-1:0] core_write_val,
  output logic [MEM_WIDTH-1:0] core_read_val,
  output logic                 core_ready,
  output logic                 stall,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  input  logic [MEM_WIDTH-1:0] ram_rdata,
  output logic                 err_both
`ifdef MEM_CTRL_ACCESS_COUNT_EN
  ,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count
`endif
);

  // Out-of-range latencies are pulled into the supported window.
  localparam int LAT_EFF = (RAM_LATENCY < LAT_MIN) ? LAT_MIN :
                           (RAM_LATENCY > LAT_MAX) ? LAT_MAX : RAM_LATENCY;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(LAT_EFF);

  state_t               state_q;
  state_t               state_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q;
  logic                 req;
  logic                 accept;
  logic                 lat_done;

  assign req      = core_read_en | core_write_en;
  assign accept   = (state_q == IDLE) && req;
  assign lat_done = (lat_cnt_q == LAT_LAST);

  // Completion pulse is simply the DONE state; stall covers the whole wait.
  assign core_ready = (state_q == DONE);
  assign stall      = req & ~core_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: writes finish in one cycle, reads wait out the RAM latency.
  // A simultaneous read+write is handled as a write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = core_write_en ? DONE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cycles spent in RD_WAIT; the first wait cycle counts as 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt_q <= '0;
    end else if (accept) begin
      lat_cnt_q <= LAT_CNT_W'(1);
    end else if ((state_q == RD_WAIT) && !lat_done) begin
      lat_cnt_q <= lat_cnt_q + 1'b1;
    end
  end

  // Request capture: address/data are frozen until the next acceptance,
  // enables and the both-requested flag are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      err_both  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en   <= accept;
      ram_we   <= accept & core_write_en;
      err_both <= accept & core_read_en & core_write_en;
      if (accept) begin
        ram_addr  <= core_addr;
        ram_wdata <= core_write_val;
      end
    end
  end

  // Read data is sampled only on the last wait cycle, so stale or
  // post-reset RAM output never reaches the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_read_val <= '0;
    end else if ((state_q == RD_WAIT) && lat_done) begin
      core_read_val <= ram_rdata;
    end
  end

`ifdef MEM_CTRL_ACCESS_COUNT_EN
  // ram_we is still high in a write's DONE cycle, so it tells the kind apart.
  logic rd_inc;
  logic wr_inc;

  assign rd_inc = core_ready & ~ram_we;
  assign wr_inc = core_ready & ram_we;

  mem_ctrl_sat_counter u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_inc),
    .count (rd_count)
  );

  mem_ctrl_sat_counter u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_inc),
    .count (wr_count)
  );
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl with RAM_LATENCY = 2: directed vector table,
// reset-abort sequence, then randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int MW = 32;
  localparam int MS = 256;
  localparam int RL = 2;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] core_addr;
  logic          core_read_en;
  logic          core_write_en;
  logic [MW-1:0] core_write_val;
  logic [MW-1:0] core_read_val;
  logic          core_ready;
  logic          stall;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic          ram_we;
  logic [MW-1:0] ram_wdata;
  logic [MW-1:0] ram_rdata;
  logic          err_both;
`ifdef MEM_CTRL_ACCESS_COUNT_EN
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
`endif

  always #5 clk = ~clk;

  mem_ctrl #(.MEM_WIDTH(MW), .MEM_SIZE(MS), .RAM_LATENCY(RL)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_addr      (core_addr),
    .core_read_en   (core_read_en),
    .core_write_en  (core_write_en),
    .core_write_val (core_write_val),
    .core_read_val  (core_read_val),
    .core_ready     (core_ready),
    .stall          (stall),
    .ram_addr       (ram_addr),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .err_both       (err_both)
`ifdef MEM_CTRL_ACCESS_COUNT_EN
    ,
    .rd_count       (rd_count),
    .wr_count       (wr_count)
`endif
  );

  // RAM model: data for an enable launched at edge E is presented on
  // ram_rdata just before edge E+RL; at any other time it shows junk.
  logic [MW-1:0] init_mem [MS];
  logic [MW-1:0] ram_mem  [MS];
  logic          ram_loaded = 1'b0;
  logic          dly_v = 1'b0;
  logic [AW-1:0] dly_a = '0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < MS; i++) ram_mem[i] <= init_mem[i];
      ram_loaded <= 1'b1;
    end else if (ram_en && ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    dly_v <= ram_en & ~ram_we;
    dly_a <= ram_addr;
  end

  assign ram_rdata = dly_v ? ram_mem[dly_a] : 32'hBADC_0FFE;

  // Reference model state: intended memory contents, last read value, counts.
  logic [MW-1:0] ref_mem [MS];
  logic [MW-1:0] model_rval;
  int            rd_n;
  int            wr_n;
  logic          in_ready;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One core transaction. If called in the ready cycle of the previous access
  // the request is presented immediately (back-to-back); else at a negedge.
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [MW-1:0] data, input logic scramble,
                           output int stall_cnt, output logic err_seen);
    int          e_acc;
    int          e_rdy;
    logic        both;
    logic [MW-1:0] rv_before;
    logic [MW-1:0] rv_after;
    logic [4:0]  got;
    logic [4:0]  exp;
    both      = rd & wr;
    rv_before = model_rval;
    if (wr) begin
      ref_mem[addr] = data;
      rv_after = model_rval;
      wr_n++;
    end else begin
      rv_after = ref_mem[addr];
      rd_n++;
    end
    model_rval = rv_after;
    stall_cnt  = 0;
    err_seen   = 1'b0;

    if (!in_ready) @(negedge clk);
    core_read_en   = rd;
    core_write_en  = wr;
    core_addr      = addr;
    core_write_val = data;
    e_acc = in_ready ? 2 : 1;
    e_rdy = e_acc + (wr ? 0 : RL);
    #1;
    check("stall_before_edge", {31'b0, stall}, {31'b0, !in_ready});
    if (stall) stall_cnt++;

    for (int e = 1; e <= e_rdy; e++) begin
      @(posedge clk);
      #1;
      exp = {e == e_acc, (e == e_acc) && wr, (e == e_acc) && both, e == e_rdy, e != e_rdy};
      got = {ram_en, ram_we, err_both, core_ready, stall};
      check("en_we_err_ready_stall", {27'b0, got}, {27'b0, exp});
      if (stall) stall_cnt++;
      if (err_both) err_seen = 1'b1;
      if (e >= e_acc) begin
        check("ram_addr_held", {24'b0, ram_addr}, {24'b0, addr});
        if (wr) check("ram_wdata_held", ram_wdata, data);
      end
      check("core_read_val", core_read_val, (e == e_rdy) ? rv_after : rv_before);
      if (scramble && e == e_acc) begin
        core_addr      = AW'($urandom);
        core_write_val = $urandom;
      end
    end
    core_read_en  = 1'b0;
    core_write_en = 1'b0;
    in_ready      = 1'b1;
  endtask

  // Quiet cycles with no request: nothing may be launched or completed.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_quiet", {30'b0, core_ready, ram_en}, 32'h0);
    end
    in_ready = 1'b0;
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
    logic          b2b;
    logic [MW-1:0] exp_rval;
    int            exp_stall;
    logic          exp_err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int   sc;
    logic es;

    tbl[0]  = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hD4, 32'h12345678, 1'b0, 32'hDEADBEEF, 1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hD5, 32'h9ABCDEF0, 1'b1, 32'hDEADBEEF, 1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'hD4, 32'h0,        1'b0, 32'h12345678, 3, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'hD5, 32'h0,        1'b1, 32'h9ABCDEF0, 3, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h20, 32'h1,        1'b0, 32'h9ABCDEF0, 1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h20, 32'h0,        1'b0, 32'h0000_0001, 3, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 1'b0, 32'h0000_0001, 1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'hFF, 32'h0,        1'b1, 32'hFFFFFFFF, 3, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 32'h0,        1'b1, 32'hFFFFFFFF, 1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 32'h5,        1'b0, 32'h0000_0000, 3, 1'b0};

    for (int i = 0; i < MS; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    model_rval     = '0;
    rd_n           = 0;
    wr_n           = 0;
    in_ready       = 1'b0;
    reset          = 1'b1;
    core_addr      = '0;
    core_read_en   = 1'b0;
    core_write_en  = 1'b0;
    core_write_val = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, core_ready}, 32'h0);
    check("rst_ram_en_we", {30'b0, ram_en, ram_we}, 32'h0);
    check("rst_err_both", {31'b0, err_both}, 32'h0);
    check("rst_read_val", core_read_val, 32'h0);
    check("rst_ram_addr", {24'b0, ram_addr}, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    reset = 1'b0;
    idle(1);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      if (!tbl[i].b2b) idle(1);
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0, sc, es);
      check($sformatf("tbl%0d_read_val", i), core_read_val, tbl[i].exp_rval);
      check($sformatf("tbl%0d_stall_cycles", i), sc, tbl[i].exp_stall);
      check($sformatf("tbl%0d_err_both", i), {31'b0, es}, {31'b0, tbl[i].exp_err});
    end

    // Reset while waiting on a read: access aborted, late data discarded
    idle(1);
    @(negedge clk);
    core_read_en = 1'b1;
    core_addr    = 8'h10;
    @(posedge clk);
    #1;
    check("abort_accepted", {31'b0, ram_en}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", {31'b0, core_ready}, 32'h0);
    check("abort_read_val", core_read_val, 32'h0);
    check("abort_ram_regs", {ram_en, ram_we, err_both, ram_addr}, 32'h0);
    check("abort_ram_wdata", ram_wdata, 32'h0);
    @(negedge clk);
    reset        = 1'b0;
    core_read_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_ready", {31'b0, core_ready}, 32'h0);
      check("abort_val_stays_0", core_read_val, 32'h0);
    end
    model_rval = '0;
    rd_n       = 0;
    wr_n       = 0;
    in_ready   = 1'b0;
    do_access(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, sc, es);
    check("after_abort_read", core_read_val, 32'hDEADBEEF);

    // Randomized traffic with inputs scrambled after acceptance
    for (int n = 0; n < 60; n++) begin
      int          k;
      logic        rd;
      logic        wr;
      logic [AW-1:0] a;
      k  = $urandom_range(0, 9);
      rd = (k < 4) || (k == 8);
      wr = (k >= 4);
      a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
      do_access(rd, wr, a, $urandom, 1'b1, sc, es);
      check("rand_stall_cycles", sc, wr ? 1 : RL + 1);
      check("rand_err_both", {31'b0, es}, {31'b0, rd & wr});
    end
    idle(1);

`ifdef MEM_CTRL_ACCESS_COUNT_EN
    check("cnt_rd_model", {16'b0, rd_count}, rd_n);
    check("cnt_wr_model", {16'b0, wr_count}, wr_n);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("cnt_rd_reset", {16'b0, rd_count}, 32'h0);
    check("cnt_wr_reset", {16'b0, wr_count}, 32'h0);
    reset = 1'b0;
    model_rval = '0;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      do_access(1'b1, 1'b0, AW'(i), 32'h0, 1'b0, sc, es);
    end
    for (int i = 0; i < 2; i++) begin
      idle(1);
      do_access(1'b0, 1'b1, AW'(8'h40 + i), $urandom, 1'b0, sc, es);
    end
    idle(1);
    check("cnt_rd_3", {16'b0, rd_count}, 32'd3);
    check("cnt_wr_2", {16'b0, wr_count}, 32'd2);
    @(negedge clk);
    force dut.u_rd_cnt.count = 16'hFFFF;
    @(negedge clk);
    release dut.u_rd_cnt.count;
    in_ready = 1'b0;
    do_access(1'b1, 1'b0, 8'h40, 32'h0, 1'b0, sc, es);
    idle(1);
    check("cnt_rd_saturated", {16'b0, rd_count}, 32'h0000FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
